// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int   DATA_W      = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // PARITY is only reachable when FIFO_UART_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

endpackage

// File: rtl/fifo_uart_if.sv
// fifo_uart_if: read side of the upstream sync FIFO.
// master = transmitter (pops), slave = FIFO (supplies flag and data).
interface fifo_uart_if;
    import fifo_uart_pkg::*;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);

endinterface

// File: rtl/fifo_uart_baud.sv
// fifo_uart_baud: bit-period counter, 0..CLKS_PER_BIT-1, with bit_end at terminal count.
module fifo_uart_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // count up, wrapping at the terminal count or when held clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || (cnt == TERM)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == TERM) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a sync FIFO and sends them as 8N1 UART frames.
// Optional: define FIFO_UART_PARITY_EN to append an even-parity bit (8E1).
// tx is registered and loaded on the edge entering each bit, so it lines up
// with the state: busy and frame_done are decoded from the same state register.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_en,
    fifo_uart_if.master   fifo,
    output logic          tx,
    output logic          busy,
    output logic          frame_done
);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              bit_end;
    logic              baud_clr;
`ifdef FIFO_UART_PARITY_EN
    logic              par;
`endif

    assign baud_clr = (state == IDLE) || (state == POP) || (state == LOAD);

    fifo_uart_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (baud_clr),
        .bit_end(bit_end)
    );

    // frame sequencer: state, shift register, bit index and serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= IDLE_LEVEL;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef FIFO_UART_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (tx_en && !fifo.fifo_empty) begin
                        state <= POP;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg <= fifo.fifo_data;
`ifdef FIFO_UART_PARITY_EN
                    par   <= ^fifo.fifo_data;
`endif
                    tx    <= START_LEVEL;
                    state <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[DATA_W-1:1]};
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= IDLE_LEVEL;
                            state <= STOP;
`endif
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[DATA_W-1:1]};
                        end
                    end
                end
`ifdef FIFO_UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= IDLE_LEVEL;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fifo.fifo_rd_en = (state == POP);
    assign busy            = (state != IDLE);
    assign frame_done      = (state == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx with CLKS_PER_BIT=4.
// Honours FIFO_UART_PARITY_EN to expect 11-bit frames.
module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * C;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic tx_en;
    logic tx;
    logic busy;
    logic frame_done;

    fifo_uart_if fif();

    fifo_uart_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo      (fif.master),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    exp_t       sb_q[$];
    logic [7:0] fifo_q[$];

    int rd_cnt      = 0;
    int frames_seen = 0;
    int last_len    = 0;
    int stray_fd    = 0;

    logic             in_frame = 1'b0;
    logic             seen_end = 1'b0;
    int               pos      = 0;
    int               bad      = 0;
    int               fd_at    = -1;
    int               gap_cnt  = 0;
    int               busy_low = 0;
    exp_t             cur;
    logic [NBITS-1:0] pat;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [NBITS-1:0] make_frame(input logic [7:0] d);
        logic [NBITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef FIFO_UART_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    task automatic push(input logic [7:0] d, input int g);
        exp_t e;
        e.data = d;
        e.gap  = g;
        fifo_q.push_back(d);
        sb_q.push_back(e);
    endtask

    // upstream FIFO model: 1-cycle read latency, registered empty flag
    always @(posedge clk) begin
        if (fif.fifo_rd_en) begin
            check("pop_nonempty", int'(fifo_q.size() > 0), 1);
            if (fifo_q.size() > 0) fif.fifo_data <= fifo_q.pop_front();
        end
        fif.fifo_empty <= (fifo_q.size() == 0);
    end

    // monitor: decodes each frame on tx and compares against the scoreboard
    always @(negedge clk) begin
        if (fif.fifo_rd_en) rd_cnt++;
        if (rst) begin
            in_frame = 1'b0;
            seen_end = 1'b0;
        end else begin
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    check("sb_has_entry", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        cur = sb_q.pop_front();
                    end else begin
                        cur.data = 8'h00;
                        cur.gap  = -1;
                    end
                    if (cur.gap >= 0 && seen_end) begin
                        check("gap_high_cycles", gap_cnt, cur.gap);
                        check("gap_busy_low", busy_low, 1);
                    end
                    pat      = make_frame(cur.data);
                    in_frame = 1'b1;
                    pos      = 0;
                    bad      = 0;
                    fd_at    = -1;
                end else begin
                    gap_cnt++;
                    if (!busy) busy_low++;
                    if (frame_done) stray_fd++;
                end
            end
            if (in_frame) begin
                if (tx !== pat[pos / C]) bad++;
                if (busy !== 1'b1) bad++;
                if (frame_done) begin
                    if (fd_at < 0) fd_at = pos;
                    else bad++;
                end
                pos++;
                if (pos == FRAME_CYC) begin
                    check($sformatf("frame_%02h_bits", cur.data), bad, 0);
                    check($sformatf("frame_%02h_done_pos", cur.data), fd_at, FRAME_CYC - 1);
                    last_len    = fd_at + 1;
                    in_frame    = 1'b0;
                    seen_end    = 1'b1;
                    gap_cnt     = 0;
                    busy_low    = 0;
                    frames_seen++;
                end
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("frames_reach_%0d", target), frames_seen, target);
    endtask

    task automatic wait_pos(input logic [7:0] d, input int p, input int budget);
        int n = 0;
        while (!(in_frame && cur.data == d && pos == p) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("reach_%02h_pos%0d", d, p), int'(in_frame && cur.data == d && pos == p), 1);
    endtask

    initial begin
        int hi;
        int bz;
        rst   = 1'b1;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fif.fifo_rd_en, 0);
        check("rst_frame_done", frame_done, 0);
        rst   = 1'b0;
        tx_en = 1'b1;

        // empty FIFO: nothing may happen
        hi = 0;
        bz = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) hi++;
            if (busy !== 1'b0) bz++;
        end
        check("idle_tx_not_high", hi, 0);
        check("idle_busy_cycles", bz, 0);
        check("idle_rd_en_count", rd_cnt, 0);

        // single byte
        push(8'hA5, -1);
        wait_frames(1, 200);
        check("a5_pop_count", rd_cnt, 1);

        // back-to-back burst
        push(8'h00, -1);
        push(8'hFF, 3);
        push(8'h3C, 3);
        wait_frames(4, 400);
        check("burst_pop_count", rd_cnt, 4);

        // tx_en dropped mid-DATA
        push(8'h55, -1);
        push(8'h11, -1);
        push(8'h22, 3);
        wait_pos(8'h55, 12, 200);
        tx_en = 1'b0;
        wait_frames(5, 200);
        repeat (20) @(negedge clk);
        check("no_pop_while_disabled", rd_cnt, 5);
        check("fifo_left_after_disable", fifo_q.size(), 2);
        tx_en = 1'b1;
        @(negedge clk);
        check("resume_rd_en", fif.fifo_rd_en, 1);
        wait_frames(7, 400);

        // reset during data bit 3
        push(8'hC3, -1);
        push(8'h5A, -1);
        wait_pos(8'hC3, 18, 200);
        rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_en", fif.fifo_rd_en, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_frames(8, 200);
        check("after_rst_pop_count", rd_cnt, 9);

        // parity-sensitive byte and frame length
        push(8'h07, -1);
        wait_frames(9, 200);
        check("frame_07_len", last_len, FRAME_CYC);

        repeat (10) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("stray_frame_done", stray_fd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
